// File: rtl/counter_pkg.sv
// counter_pkg -- definitions shared by the lab counters.
//   timer_state_e          : countdown_timer FSM encoding (2 bits).
//   COUNTER_WIDTH_DEFAULT  : default counter width, common to the up-counter
//                            and the countdown timer.
package counter_pkg;

   localparam int COUNTER_WIDTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } timer_state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if -- control/status bundle of the countdown timer.
// Handshake: there is no valid/ready pair. Every control input (enable, load,
// load_value, start, abort) is a level sampled on each rising clock edge, and
// every status output (count_out, busy, done, load_err, state) is valid for the
// whole cycle following the edge that produced it.
//   master : drives the controls, observes the status (lab controller, bench)
//   slave  : the timer itself
//   state  : debug view of the timer FSM
interface countdown_timer_if
   import counter_pkg::*;
#(
   parameter int WIDTH = COUNTER_WIDTH_DEFAULT
);
   logic             enable;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] count_out;
   logic             busy;
   logic             done;
   logic             load_err;
   timer_state_e     state;

   modport master (
      output enable, load, load_value, start, abort,
      input  count_out, busy, done, load_err, state
   );

   modport slave (
      input  enable, load, load_value, start, abort,
      output count_out, busy, done, load_err, state
   );
endinterface

// File: rtl/countdown_core.sv
// countdown_core -- loadable down register for the countdown timer.
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   clear          : force count to 0 (highest priority)
//   load           : take load_value into count and the reload register
//   reload         : restore count from the reload register
//   dec            : decrement count by one
//   load_value     : value for load
//   count          : current count (registered)
//   count_is_one   : count == 1, i.e. the next decrement reaches zero
// With no control asserted the count holds.
module countdown_core #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic             reload,
   input  logic             dec,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             count_is_one
);

   logic [WIDTH-1:0] reload_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         count      <= '0;
         reload_reg <= '0;
      end else begin
         if (load) begin
            reload_reg <= load_value;
         end
         if (clear) begin
            count <= '0;
         end else if (load) begin
            count <= load_value;
         end else if (reload) begin
            count <= reload_reg;
         end else if (dec) begin
            count <= count - WIDTH'(1);
         end
      end
   end

   assign count_is_one = (count == WIDTH'(1));

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer -- loadable down-counting timer with one-cycle done pulse.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : countdown_timer_if.slave (enable, load, load_value, start, abort
//            in; count_out, busy, done, load_err, state out)
// FSM: IDLE -> (load N!=0) ARMED -> (start) RUN -> (count 1 & enable) DONE.
// Edge priority: reset > abort > load > start > enable.
// Optional feature macro COUNTDOWN_TIMER_AUTO_RELOAD_EN: when defined, DONE
// returns to RUN with the count restored from the reload register (periodic
// timer, period N+1); when undefined, DONE returns to IDLE (one-shot).
module countdown_timer
   import counter_pkg::*;
#(
   parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
   input logic               clock,
   input logic               reset,
   countdown_timer_if.slave  bus
);

   timer_state_e     state, state_next;
   logic             load_err, load_err_next;
   logic             core_clear, core_load, core_reload, core_dec;
   logic [WIDTH-1:0] count;
   logic             count_is_one;
   logic             load_nonzero;

   countdown_core #(.WIDTH(WIDTH)) u_core (
      .clock        (clock),
      .reset        (reset),
      .clear        (core_clear),
      .load         (core_load),
      .reload       (core_reload),
      .dec          (core_dec),
      .load_value   (bus.load_value),
      .count        (count),
      .count_is_one (count_is_one)
   );

   assign load_nonzero = (bus.load_value != '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         load_err <= 1'b0;
      end else begin
         state    <= state_next;
         load_err <= load_err_next;
      end
   end

   always_comb begin
      state_next    = state;
      load_err_next = 1'b0;
      core_clear    = 1'b0;
      core_load     = 1'b0;
      core_reload   = 1'b0;
      core_dec      = 1'b0;
      case (state)
         IDLE: begin
            // abort has nothing to cancel here, so a load still proceeds
            if (bus.load) begin
               if (load_nonzero) begin
                  core_load  = 1'b1;
                  state_next = ARMED;
               end else begin
                  load_err_next = 1'b1;
               end
            end
         end
         ARMED: begin
            if (bus.abort) begin
               core_clear = 1'b1;
               state_next = IDLE;
            end else if (bus.load) begin
               // any load, even a rejected one, takes precedence over start
               if (load_nonzero) begin
                  core_load = 1'b1;
               end else begin
                  load_err_next = 1'b1;
               end
            end else if (bus.start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (bus.abort) begin
               core_clear = 1'b1;
               state_next = IDLE;
            end else begin
               // a rejected load does not stall the countdown
               load_err_next = bus.load;
               if (bus.enable) begin
                  core_dec = 1'b1;
                  if (count_is_one) begin
                     state_next = DONE;
                  end
               end
            end
         end
         DONE: begin
            load_err_next = bus.load;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            core_reload = 1'b1;
            state_next  = RUN;
`else
            state_next  = IDLE;
`endif
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.count_out = count;
   assign bus.busy      = (state == RUN);
   assign bus.done      = (state == DONE);
   assign bus.load_err  = load_err;
   assign bus.state     = state;

endmodule
